// File: rtl/dac8568_pkg.sv
// Shared constants, field positions and FSM encoding for the DAC8568 frame receiver.
package dac8568_pkg;

    localparam int FRAME_BITS = 32;
    localparam int NUM_CH     = 8;
    localparam int CNT_W      = 6;
    localparam int DATA_W     = 16;

    localparam logic [3:0] CMD_WRITE_INPUT      = 4'h0;
    localparam logic [3:0] CMD_UPDATE           = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'h2;
    localparam logic [3:0] CMD_WRITE_UPDATE     = 4'h3;
    localparam logic [3:0] CMD_REF              = 4'h8;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    localparam int PREFIX_MSB  = 31;
    localparam int PREFIX_LSB  = 28;
    localparam int CMD_MSB     = 27;
    localparam int CMD_LSB     = 24;
    localparam int ADDR_MSB    = 23;
    localparam int ADDR_LSB    = 20;
    localparam int DATA_MSB    = 19;
    localparam int DATA_LSB    = 4;
    localparam int FEATURE_MSB = 3;
    localparam int FEATURE_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_DECODE    = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_e;

    // One-hot channel select; 0-7 pick one channel, ADDR_ALL picks every channel.
    function automatic logic [NUM_CH-1:0] chan_mask(input logic [3:0] addr);
        logic [NUM_CH-1:0] m;
        m = '0;
        if (addr == ADDR_ALL) begin
            m = '1;
        end else if (addr[3] == 1'b0) begin
            m[addr[2:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/dac8568_frame_receiver_sync_edge.sv
// Two-flop synchronizer with a history flop for edge detection on an async pin.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // Resync chain followed by one cycle of history for the edge compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/dac8568_frame_receiver.sv
// DAC8568 serial responder: deframes 32-bit words and keeps a shadow of the
// input registers, DAC registers and internal-reference flag.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for SYNC fall, bit counter held at zero
// ST_SHIFT     | shifting DIN on SCLK falls; short frame on early SYNC rise
// ST_DECODE    | one cycle: latch fields, apply command, pulse frame_valid
// ST_WAIT_HIGH | frame done, SCLK ignored until SYNC returns high
module dac8568_frame_receiver
    import dac8568_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dac_clk,
    input  logic                       dac_sync,
    input  logic                       dac_din,
    output logic                       frame_valid,
    output logic [3:0]                 frame_cmd,
    output logic [3:0]                 frame_addr,
    output logic [15:0]                frame_data,
    output logic [3:0]                 frame_feature,
    output logic                       frame_error,
    output logic [NUM_CH-1:0]          dac_update,
    output logic [NUM_CH*DATA_W-1:0]   dac_values,
    output logic                       ref_enable
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic sync_level, sync_rise, sync_fall;
    logic din_level, din_rise, din_fall;

    sync_edge u_sync_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(dac_clk),
        .level   (sclk_level),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    sync_edge u_sync_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(dac_sync),
        .level   (sync_level),
        .rise    (sync_rise),
        .fall    (sync_fall)
    );

    sync_edge u_sync_din (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_in(dac_din),
        .level   (din_level),
        .rise    (din_rise),
        .fall    (din_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_level, sclk_rise, din_rise, din_fall};

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [DATA_W-1:0]  input_q [NUM_CH];
    logic [DATA_W-1:0]  dac_q   [NUM_CH];
    logic [DATA_W-1:0]  input_d [NUM_CH];
    logic [DATA_W-1:0]  dac_d   [NUM_CH];

    logic               frame_valid_q;
    logic               frame_error_q;
    logic [NUM_CH-1:0]  dac_update_q;
    logic [3:0]         frame_cmd_q;
    logic [3:0]         frame_addr_q;
    logic [15:0]        frame_data_q;
    logic [3:0]         frame_feature_q;
    logic               ref_enable_q;

    logic [3:0]         w_prefix;
    logic [3:0]         w_cmd;
    logic [3:0]         w_addr;
    logic [15:0]        w_data;
    logic [3:0]         w_feature;
    logic [NUM_CH-1:0]  sel_mask;
    logic               addr_ok;
    logic               cmd_known;
    logic               cmd_ok;
    logic               wr_input;
    logic [NUM_CH-1:0]  upd_mask;
    logic               last_bit;

    assign w_prefix  = shift_q[PREFIX_MSB:PREFIX_LSB];
    assign w_cmd     = shift_q[CMD_MSB:CMD_LSB];
    assign w_addr    = shift_q[ADDR_MSB:ADDR_LSB];
    assign w_data    = shift_q[DATA_MSB:DATA_LSB];
    assign w_feature = shift_q[FEATURE_MSB:FEATURE_LSB];
    assign last_bit  = (cnt_q == CNT_W'(FRAME_BITS - 1));

    // Classify the received word and work out which registers it touches.
    always_comb begin
        sel_mask  = chan_mask(w_addr);
        addr_ok   = (w_addr[3] == 1'b0) || (w_addr == ADDR_ALL);
        cmd_known = (w_cmd == CMD_WRITE_INPUT) || (w_cmd == CMD_UPDATE) ||
                    (w_cmd == CMD_WRITE_UPDATE_ALL) || (w_cmd == CMD_WRITE_UPDATE) ||
                    (w_cmd == CMD_REF);
        cmd_ok    = (w_prefix == 4'h0) && addr_ok && cmd_known;
        wr_input  = cmd_ok && ((w_cmd == CMD_WRITE_INPUT) ||
                               (w_cmd == CMD_WRITE_UPDATE_ALL) ||
                               (w_cmd == CMD_WRITE_UPDATE));
        upd_mask  = '0;
        if (cmd_ok) begin
            if ((w_cmd == CMD_UPDATE) || (w_cmd == CMD_WRITE_UPDATE)) begin
                upd_mask = sel_mask;
            end else if (w_cmd == CMD_WRITE_UPDATE_ALL) begin
                upd_mask = '1;
            end
        end
    end

    // Next register contents; DAC copies see the freshly written input value.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            input_d[n] = (wr_input && sel_mask[n]) ? w_data : input_q[n];
            dac_d[n]   = upd_mask[n] ? input_d[n] : dac_q[n];
        end
    end

    // Frame FSM, shift register, register shadows and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            shift_q         <= '0;
            frame_valid_q   <= 1'b0;
            frame_error_q   <= 1'b0;
            dac_update_q    <= '0;
            frame_cmd_q     <= '0;
            frame_addr_q    <= '0;
            frame_data_q    <= '0;
            frame_feature_q <= '0;
            ref_enable_q    <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                input_q[n] <= '0;
                dac_q[n]   <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            dac_update_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (sync_fall) begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A SYNC rise landing with the 32nd fall still completes the frame.
                    if (sclk_fall && last_bit) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], din_level};
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= ST_DECODE;
                    end else if (sync_rise) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (sclk_fall) begin
                        shift_q <= {shift_q[FRAME_BITS-2:0], din_level};
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DECODE: begin
                    frame_valid_q   <= 1'b1;
                    frame_error_q   <= ~cmd_ok;
                    dac_update_q    <= upd_mask;
                    frame_cmd_q     <= w_cmd;
                    frame_addr_q    <= w_addr;
                    frame_data_q    <= w_data;
                    frame_feature_q <= w_feature;
                    input_q         <= input_d;
                    dac_q           <= dac_d;
                    if (cmd_ok && (w_cmd == CMD_REF)) begin
                        ref_enable_q <= w_feature[0];
                    end
                    // SYNC may already be high (or even low again) after a coincident end.
                    if (sync_fall) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else if (sync_level) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (sync_fall) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else if (sync_level) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the DAC register array onto the output bus.
    always_comb begin
        dac_values = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            dac_values[DATA_W*n +: DATA_W] = dac_q[n];
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_error   = frame_error_q;
    assign dac_update    = dac_update_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_addr    = frame_addr_q;
    assign frame_data    = frame_data_q;
    assign frame_feature = frame_feature_q;
    assign ref_enable    = ref_enable_q;

endmodule

// File: tb/tb_dac8568_frame_receiver.sv
// Directed bench for the DAC8568 frame receiver; SCLK runs at clk/8.
module tb_dac8568_frame_receiver;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         dac_clk = 1'b0;
    logic         dac_sync = 1'b1;
    logic         dac_din = 1'b0;
    logic         frame_valid;
    logic [3:0]   frame_cmd;
    logic [3:0]   frame_addr;
    logic [15:0]  frame_data;
    logic [3:0]   frame_feature;
    logic         frame_error;
    logic [7:0]   dac_update;
    logic [127:0] dac_values;
    logic         ref_enable;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    logic [7:0] last_upd = 8'h00;

    dac8568_frame_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dac_clk      (dac_clk),
        .dac_sync     (dac_sync),
        .dac_din      (dac_din),
        .frame_valid  (frame_valid),
        .frame_cmd    (frame_cmd),
        .frame_addr   (frame_addr),
        .frame_data   (frame_data),
        .frame_feature(frame_feature),
        .frame_error  (frame_error),
        .dac_update   (dac_update),
        .dac_values   (dac_values),
        .ref_enable   (ref_enable)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_valid) begin
            n_valid  = n_valid + 1;
            last_upd = dac_update;
        end
        if (frame_error) n_err = n_err + 1;
    end

    function automatic logic [31:0] mk(input logic [3:0] cmd, input logic [3:0] addr,
                                       input logic [15:0] data, input logic [3:0] feat);
        return {4'h0, cmd, addr, data, feat};
    endfunction

    task automatic drive_bits(input logic [31:0] w, input int msb, input int n);
        for (int i = 0; i < n; i++) begin
            dac_clk = 1'b1;
            dac_din = w[msb - i];
            #40;
            dac_clk = 1'b0;
            #40;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int n, input bit coincident);
        dac_sync = 1'b0;
        #40;
        if (coincident) begin
            drive_bits(w, 31, n - 1);
            dac_clk = 1'b1;
            dac_din = w[31 - (n - 1)];
            #40;
            dac_clk  = 1'b0;
            dac_sync = 1'b1;
        end else begin
            drive_bits(w, 31, n);
            #40;
            dac_sync = 1'b1;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", frame_valid); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL rst_error: got %b expected 0", frame_error); else n_pass++;
        n_checks++; if (dac_update !== 8'h00) $display("FAIL rst_update: got %h expected 00", dac_update); else n_pass++;
        n_checks++; if (dac_values !== 128'h0) $display("FAIL rst_values: got %h expected 0", dac_values); else n_pass++;
        n_checks++; if (ref_enable !== 1'b0) $display("FAIL rst_ref: got %b expected 0", ref_enable); else n_pass++;
        n_checks++; if ({frame_cmd, frame_addr, frame_data, frame_feature} !== 28'h0)
            $display("FAIL rst_fields: got %h expected 0", {frame_cmd, frame_addr, frame_data, frame_feature}); else n_pass++;
    endtask

    task automatic test_write_update;
        int bv, be;
        bv = n_valid; be = n_err;
        send_frame(mk(4'h3, 4'h2, 16'hABCD, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (n_valid - bv !== 1) $display("FAIL wu_valid_count: got %0d expected 1", n_valid - bv); else n_pass++;
        n_checks++; if (n_err - be !== 0) $display("FAIL wu_error_count: got %0d expected 0", n_err - be); else n_pass++;
        n_checks++; if (last_upd !== 8'h04) $display("FAIL wu_update: got %h expected 04", last_upd); else n_pass++;
        n_checks++; if (dac_values[47:32] !== 16'hABCD) $display("FAIL wu_ch2: got %h expected abcd", dac_values[47:32]); else n_pass++;
        n_checks++; if ({frame_cmd, frame_addr, frame_data} !== 24'h32ABCD)
            $display("FAIL wu_fields: got %h expected 32abcd", {frame_cmd, frame_addr, frame_data}); else n_pass++;
        n_checks++; if (frame_valid !== 1'b0) $display("FAIL wu_valid_pulse: got %b expected 0", frame_valid); else n_pass++;
    endtask

    task automatic test_input_then_update;
        send_frame(mk(4'h0, 4'h5, 16'h1234, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (last_upd !== 8'h00) $display("FAIL in_update: got %h expected 00", last_upd); else n_pass++;
        n_checks++; if (dac_values[95:80] !== 16'h0000) $display("FAIL in_ch5: got %h expected 0000", dac_values[95:80]); else n_pass++;
        send_frame(mk(4'h1, 4'h5, 16'h0000, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (last_upd !== 8'h20) $display("FAIL upd_update: got %h expected 20", last_upd); else n_pass++;
        n_checks++; if (dac_values[95:80] !== 16'h1234) $display("FAIL upd_ch5: got %h expected 1234", dac_values[95:80]); else n_pass++;
    endtask

    task automatic test_update_all;
        logic [127:0] exp;
        exp = {16'h7777, 16'h0000, 16'h1234, 16'h0000, 16'h3333, 16'hABCD, 16'h0000, 16'h1111};
        send_frame(mk(4'h0, 4'h0, 16'h1111, 4'h0), 32, 1'b0);
        #200;
        send_frame(mk(4'h0, 4'h7, 16'h7777, 4'h0), 32, 1'b0);
        #200;
        send_frame(mk(4'h2, 4'h3, 16'h3333, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (last_upd !== 8'hFF) $display("FAIL all_update: got %h expected ff", last_upd); else n_pass++;
        n_checks++; if (dac_values !== exp) $display("FAIL all_values: got %h expected %h", dac_values, exp); else n_pass++;
    endtask

    task automatic test_short_frame;
        int bv, be;
        logic [127:0] exp;
        exp = {16'h7777, 16'h0000, 16'h1234, 16'h0000, 16'h3333, 16'hABCD, 16'h0000, 16'h1111};
        bv = n_valid; be = n_err;
        send_frame(mk(4'h3, 4'h0, 16'hDEAD, 4'h0), 20, 1'b0);
        #200;
        n_checks++; if (n_err - be !== 1) $display("FAIL short_error: got %0d expected 1", n_err - be); else n_pass++;
        n_checks++; if (n_valid - bv !== 0) $display("FAIL short_valid: got %0d expected 0", n_valid - bv); else n_pass++;
        n_checks++; if (dac_values !== exp) $display("FAIL short_values: got %h expected %h", dac_values, exp); else n_pass++;
        send_frame(mk(4'h3, 4'h1, 16'h5555, 4'h0), 32, 1'b0);
        #200;
        exp[31:16] = 16'h5555;
        n_checks++; if (last_upd !== 8'h02) $display("FAIL short_next_update: got %h expected 02", last_upd); else n_pass++;
        n_checks++; if (dac_values !== exp) $display("FAIL short_next_values: got %h expected %h", dac_values, exp); else n_pass++;
    endtask

    task automatic test_ref;
        int bv, be;
        logic [127:0] exp;
        exp = {16'h7777, 16'h0000, 16'h1234, 16'h0000, 16'h3333, 16'hABCD, 16'h5555, 16'h1111};
        bv = n_valid; be = n_err;
        send_frame(mk(4'h8, 4'h0, 16'h0000, 4'h1), 32, 1'b0);
        #200;
        n_checks++; if (ref_enable !== 1'b1) $display("FAIL ref_set: got %b expected 1", ref_enable); else n_pass++;
        n_checks++; if (n_err - be !== 0) $display("FAIL ref_error: got %0d expected 0", n_err - be); else n_pass++;
        n_checks++; if (frame_feature !== 4'h1) $display("FAIL ref_feature: got %h expected 1", frame_feature); else n_pass++;
        send_frame(mk(4'h5, 4'h0, 16'h9999, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (n_valid - bv !== 2) $display("FAIL bad_cmd_valid: got %0d expected 2", n_valid - bv); else n_pass++;
        n_checks++; if (n_err - be !== 1) $display("FAIL bad_cmd_error: got %0d expected 1", n_err - be); else n_pass++;
        n_checks++; if (ref_enable !== 1'b1) $display("FAIL bad_cmd_ref: got %b expected 1", ref_enable); else n_pass++;
        n_checks++; if (frame_cmd !== 4'h5) $display("FAIL bad_cmd_field: got %h expected 5", frame_cmd); else n_pass++;
        n_checks++; if (dac_values !== exp) $display("FAIL bad_cmd_values: got %h expected %h", dac_values, exp); else n_pass++;
    endtask

    task automatic test_bad_addr_prefix;
        int be;
        logic [127:0] exp;
        exp = {16'h7777, 16'h0000, 16'h1234, 16'h0000, 16'h3333, 16'hABCD, 16'h5555, 16'h1111};
        be = n_err;
        send_frame(mk(4'h3, 4'h9, 16'h4444, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (n_err - be !== 1) $display("FAIL addr9_error: got %0d expected 1", n_err - be); else n_pass++;
        n_checks++; if (last_upd !== 8'h00) $display("FAIL addr9_update: got %h expected 00", last_upd); else n_pass++;
        send_frame(32'h1310_0000, 32, 1'b0);
        #200;
        n_checks++; if (n_err - be !== 2) $display("FAIL prefix_error: got %0d expected 2", n_err - be); else n_pass++;
        n_checks++; if (dac_values !== exp) $display("FAIL prefix_values: got %h expected %h", dac_values, exp); else n_pass++;
    endtask

    task automatic test_addr_all;
        send_frame(mk(4'h3, 4'hF, 16'hBEEF, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (last_upd !== 8'hFF) $display("FAIL addrall_update: got %h expected ff", last_upd); else n_pass++;
        n_checks++; if (dac_values !== {8{16'hBEEF}}) $display("FAIL addrall_values: got %h expected %h", dac_values, {8{16'hBEEF}}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int bv, be;
        bv = n_valid; be = n_err;
        send_frame(mk(4'h3, 4'h4, 16'h0A0A, 4'h0), 32, 1'b1);
        #20;
        send_frame(mk(4'h3, 4'h6, 16'h0B0B, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (n_valid - bv !== 2) $display("FAIL b2b_valid: got %0d expected 2", n_valid - bv); else n_pass++;
        n_checks++; if (n_err - be !== 0) $display("FAIL b2b_error: got %0d expected 0", n_err - be); else n_pass++;
        n_checks++; if (dac_values[79:64] !== 16'h0A0A) $display("FAIL b2b_ch4: got %h expected 0a0a", dac_values[79:64]); else n_pass++;
        n_checks++; if (dac_values[111:96] !== 16'h0B0B) $display("FAIL b2b_ch6: got %h expected 0b0b", dac_values[111:96]); else n_pass++;
        n_checks++; if (last_upd !== 8'h40) $display("FAIL b2b_update: got %h expected 40", last_upd); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        int bv, be;
        logic [31:0] w;
        w = mk(4'h3, 4'h1, 16'h7E7E, 4'h0);
        bv = n_valid; be = n_err;
        dac_sync = 1'b0;
        #40;
        drive_bits(w, 31, 12);
        rst_n = 1'b0;
        #30;
        n_checks++; if (dac_values !== 128'h0) $display("FAIL midrst_values: got %h expected 0", dac_values); else n_pass++;
        rst_n = 1'b1;
        drive_bits(w, 19, 20);
        #40;
        dac_sync = 1'b1;
        #200;
        n_checks++; if (n_valid - bv !== 0) $display("FAIL midrst_valid: got %0d expected 0", n_valid - bv); else n_pass++;
        n_checks++; if (n_err - be !== 0) $display("FAIL midrst_error: got %0d expected 0", n_err - be); else n_pass++;
        n_checks++; if (dac_values !== 128'h0) $display("FAIL midrst_after: got %h expected 0", dac_values); else n_pass++;
        n_checks++; if (ref_enable !== 1'b0) $display("FAIL midrst_ref: got %b expected 0", ref_enable); else n_pass++;
        n_checks++; if (frame_cmd !== 4'h0) $display("FAIL midrst_cmd: got %h expected 0", frame_cmd); else n_pass++;
        send_frame(mk(4'h3, 4'h0, 16'h0042, 4'h0), 32, 1'b0);
        #200;
        n_checks++; if (n_valid - bv !== 1) $display("FAIL midrst_next_valid: got %0d expected 1", n_valid - bv); else n_pass++;
        n_checks++; if (dac_values !== 128'h0042) $display("FAIL midrst_next_values: got %h expected 42", dac_values); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        test_reset();
        rst_n = 1'b1;
        #100;
        test_reset();
        test_write_update();
        test_input_then_update();
        test_update_all();
        test_short_frame();
        test_ref();
        test_bad_addr_prefix();
        test_addr_all();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
